// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Address/data width follows the project-wide CPU_WIDTH define.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

package ifu_pkg;

   localparam int XLEN      = `CPU_WIDTH;
   localparam int ILEN      = 32;
   localparam int TMO_CNT_W = 16;

   localparam logic [ILEN-1:0] FAULT_INS = 32'h0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } ifu_state_e;

   // Pick the 32-bit instruction out of an 8-byte line by pc[2].
   function automatic logic [ILEN-1:0] sel_half(input logic [XLEN-1:0] line, input logic hi);
      return hi ? line[2*ILEN-1:ILEN] : line[ILEN-1:0];
   endfunction

endpackage

// File: rtl/ifu_linebuf.sv
// One-entry line buffer: remembers the last error-free 8-byte line fetched.
// Invalidate has priority over a same-cycle write.
module ifu_linebuf
   import ifu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            inval_i,
   input  logic            wr_en_i,
   input  logic [XLEN-4:0] wr_tag_i,
   input  logic [XLEN-1:0] wr_data_i,
   input  logic [XLEN-4:0] rd_tag_i,
   output logic            hit_o,
   output logic [XLEN-1:0] rd_data_o
);

   logic            valid_q;
   logic [XLEN-4:0] tag_q;
   logic [XLEN-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else if (inval_i) begin
         valid_q <= 1'b0;
      end else if (wr_en_i) begin
         valid_q <= 1'b1;
         tag_q   <= wr_tag_i;
         data_q  <= wr_data_i;
      end
   end

   assign hit_o     = valid_q && (tag_q == rd_tag_i);
   assign rd_data_o = data_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one fetch in flight, 8-byte reads, faults on misalign/error/timeout.
// Defining IFU_LINEBUF_EN adds a one-entry line buffer giving 1-cycle hits.
//   state | meaning
//   IDLE  | ready for a new pc
//   REQ   | mem_req held with stable mem_addr until mem_gnt
//   WAIT  | granted, waiting for mem_rvalid, timeout counter running
//   RESP  | ins_valid held with stable ins/ins_fault until ins_ready
//   DRAIN | flushed after grant, swallowing the late response
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_valid,
   input  logic [XLEN-1:0] pc,
   output logic            pc_ready,
   output logic            ins_valid,
   output logic [ILEN-1:0] ins,
   output logic            ins_fault,
   input  logic            ins_ready,
   input  logic            flush,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_err
);

   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(MEM_TIMEOUT - 1);

   ifu_state_e           state_q, state_d;
   logic [XLEN-1:3]      line_q, line_d;
   logic                 hi_q, hi_d;
   logic [ILEN-1:0]      ins_q, ins_d;
   logic                 fault_q, fault_d;
   logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

   logic            accept;
   logic            tmo_hit;
   logic            lb_hit;
   logic [XLEN-1:0] lb_data;

   assign pc_ready  = (state_q == ST_IDLE) && !flush;
   assign accept    = pc_valid && pc_ready;
   assign tmo_hit   = (cnt_q == TMO_LAST);
   assign ins_valid = (state_q == ST_RESP);
   assign mem_req   = (state_q == ST_REQ);
   assign mem_addr  = {line_q, 3'b000};
   assign ins       = ins_q;
   assign ins_fault = fault_q;

`ifdef IFU_LINEBUF_EN
   logic lb_wr;

   // Only clean, unflushed responses are worth keeping.
   assign lb_wr = (state_q == ST_WAIT) && mem_rvalid && !mem_err && !flush;

   ifu_linebuf u_linebuf (
      .clk      (clk),
      .rst      (rst),
      .inval_i  (flush),
      .wr_en_i  (lb_wr),
      .wr_tag_i (line_q),
      .wr_data_i(mem_rdata),
      .rd_tag_i (pc[XLEN-1:3]),
      .hit_o    (lb_hit),
      .rd_data_o(lb_data)
   );
`else
   assign lb_hit  = 1'b0;
   assign lb_data = '0;
`endif

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      hi_d    = hi_q;
      ins_d   = ins_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               line_d = pc[XLEN-1:3];
               hi_d   = pc[2];
               if (pc[1:0] != 2'b00) begin
                  state_d = ST_RESP;
                  ins_d   = FAULT_INS;
                  fault_d = 1'b1;
               end else if (lb_hit) begin
                  state_d = ST_RESP;
                  ins_d   = sel_half(lb_data, pc[2]);
                  fault_d = 1'b0;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               state_d = flush ? ST_DRAIN : ST_WAIT;
               cnt_d   = '0;
            end else if (flush) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RESP;
                  ins_d   = sel_half(mem_rdata, hi_q);
                  fault_d = mem_err;
               end
            end else if (tmo_hit) begin
               // A flush arriving with the timeout has nothing left to drain.
               state_d = flush ? ST_IDLE : ST_RESP;
               ins_d   = flush ? ins_q : FAULT_INS;
               fault_d = flush ? fault_q : 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (flush) state_d = ST_DRAIN;
            end
         end
         ST_RESP: begin
            if (flush || ins_ready) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (mem_rvalid || tmo_hit) state_d = ST_IDLE;
            else                       cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         line_q  <= '0;
         hi_q    <= 1'b0;
         ins_q   <= FAULT_INS;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         hi_q    <= hi_d;
         ins_q   <= ins_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level reference model, directed scenarios, random traffic.
module tb_ifu_fetch;

   localparam int TMO = 8;
`ifdef IFU_LINEBUF_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        pc_valid;
   logic [63:0] pc;
   logic        pc_ready;
   logic        ins_valid;
   logic [31:0] ins;
   logic        ins_fault;
   logic        ins_ready;
   logic        flush;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        mem_err;

   int total = 0;
   int bad   = 0;

   ifu_fetch #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
      .ins_valid(ins_valid), .ins(ins), .ins_fault(ins_fault), .ins_ready(ins_ready),
      .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one fetch "in flight" described by what has happened to it so far.
   bit          m_known = 0;
   bit          m_busy, m_out, m_drop, m_resp, m_hi, m_fault;
   logic [63:0] m_addr;
   logic [31:0] m_ins;
   int          m_waited;
   bit          lb_v;
   logic [60:0] lb_tag;
   logic [63:0] lb_data;

   function automatic logic [31:0] half(input logic [63:0] d, input bit hi);
      return hi ? d[63:32] : d[31:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      if (m_known) begin
         chk("pc_ready", pc_ready, !m_busy && !flush);
         chk("ins_valid", ins_valid, m_resp);
         chk("mem_req", mem_req, m_busy && !m_resp && !m_out);
         chk("mem_addr", mem_addr, m_addr);
         if (m_resp) begin
            chk("ins", ins, m_ins);
            chk("ins_fault", ins_fault, m_fault);
         end
      end
   endtask

   task automatic drv(input logic r, input logic pv, input logic [63:0] p, input logic ir,
                      input logic fl, input logic g, input logic rv, input logic [63:0] rd,
                      input logic er);
      @(negedge clk);
      rst = r; pc_valid = pv; pc = p; ins_ready = ir; flush = fl;
      mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; mem_err = er;
      #1;
      cmp_model();
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_known = 1; m_busy = 0; m_out = 0; m_drop = 0; m_resp = 0;
         m_addr = '0; m_waited = 0; lb_v = 0;
      end else if (m_known) begin
         if (!m_busy) begin
            if (pc_valid && !flush) begin
               m_busy = 1; m_out = 0; m_drop = 0; m_resp = 0;
               m_addr = {pc[63:3], 3'b000}; m_hi = pc[2];
               if (pc[1:0] != 2'b00) begin
                  m_resp = 1; m_ins = 32'h0; m_fault = 1;
               end else if (LB && lb_v && lb_tag == pc[63:3]) begin
                  m_resp = 1; m_ins = half(lb_data, pc[2]); m_fault = 0;
               end
            end
         end else if (m_resp) begin
            if (flush || ins_ready) begin m_busy = 0; m_resp = 0; end
         end else if (!m_out) begin
            if (mem_gnt) begin m_out = 1; m_waited = 0; m_drop = flush; end
            else if (flush) m_busy = 0;
         end else begin
            if (mem_rvalid) begin
               m_out = 0;
               if (m_drop || flush) m_busy = 0;
               else begin
                  m_resp = 1; m_ins = half(mem_rdata, m_hi); m_fault = mem_err;
                  if (LB && !mem_err) begin lb_v = 1; lb_tag = m_addr[63:3]; lb_data = mem_rdata; end
               end
            end else begin
               m_waited++;
               if (m_waited >= TMO) begin
                  m_out = 0;
                  if (m_drop || flush) m_busy = 0;
                  else begin m_resp = 1; m_ins = 32'h0; m_fault = 1; end
               end else if (flush) m_drop = 1;
            end
         end
         if (LB && flush) lb_v = 0;
      end
   endtask

   task automatic idle_cyc();
      drv(0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
      tick();
   endtask

   initial begin
      logic [63:0] rd;
      int rv_div;
      rst = 1; pc_valid = 0; pc = '0; ins_ready = 0; flush = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;

      // Reset values
      drv(1, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0); tick();
      drv(1, 1, 64'h8000_0000, 0, 0, 1, 1, 64'hdead_beef_dead_beef, 0); tick();
      drv(0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
      chk("rst_pc_ready", pc_ready, 1'b1);
      chk("rst_ins_valid", ins_valid, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_ins", ins, 32'h0);
      chk("rst_ins_fault", ins_fault, 1'b0);
      tick();

      // Aligned hit in the upper half, minimum latency
      drv(0, 1, 64'h8000_0004, 0, 0, 0, 0, 64'h0, 0);
      chk("t1_accept", pc_ready, 1'b1);
      tick();
      drv(0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0);
      chk("t1_req", mem_req, 1'b1);
      chk("t1_addr", mem_addr, 64'h8000_0000);
      tick();
      drv(0, 0, 64'h0, 0, 0, 0, 1, 64'h0010_0093_0000_0513, 0);
      chk("t1_wait_novalid", ins_valid, 1'b0);
      tick();
      drv(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 0);
      chk("t1_ins_valid", ins_valid, 1'b1);
      chk("t1_ins", ins, 32'h0010_0093);
      chk("t1_fault", ins_fault, 1'b0);
      tick();
      drv(0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
      chk("t1_ready_again", pc_ready, 1'b1);
      tick();

      // Misaligned pc faults without touching memory
      drv(0, 1, 64'h8000_0002, 0, 0, 0, 0, 64'h0, 0); tick();
      drv(0, 0, 64'h0, 1, 0, 1, 1, 64'h1234_5678_9abc_def0, 0);
      chk("t2_no_req", mem_req, 1'b0);
      chk("t2_ins_valid", ins_valid, 1'b1);
      chk("t2_ins", ins, 32'h0);
      chk("t2_fault", ins_fault, 1'b1);
      tick();

      // Grant withheld 4 cycles, then an error response
      drv(0, 1, 64'h8000_0010, 0, 0, 0, 0, 64'h0, 0); tick();
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 64'h0, 0, 0, 0, 1, 64'h5555_5555_5555_5555, 0);
         chk("t3_req_held", mem_req, 1'b1);
         chk("t3_addr_stable", mem_addr, 64'h8000_0010);
         tick();
      end
      drv(0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0);
      chk("t3_addr_at_gnt", mem_addr, 64'h8000_0010);
      tick();
      drv(0, 0, 64'h0, 0, 0, 0, 1, 64'hcafe_f00d_0bad_0bad, 1); tick();
      drv(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 0);
      chk("t3_ins_valid", ins_valid, 1'b1);
      chk("t3_fault", ins_fault, 1'b1);
      tick();

      // Flush in WAIT, response 2 cycles later is swallowed
      drv(0, 1, 64'h8000_0020, 0, 0, 0, 0, 64'h0, 0); tick();
      drv(0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0); tick();
      drv(0, 0, 64'h0, 0, 1, 0, 0, 64'h0, 0);
      chk("t4_flush_busy", pc_ready, 1'b0);
      tick();
      drv(0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
      chk("t4_drain_a", ins_valid, 1'b0);
      tick();
      drv(0, 0, 64'h0, 0, 0, 0, 1, 64'h1111_2222_3333_4444, 0);
      chk("t4_drain_b", ins_valid, 1'b0);
      chk("t4_drain_busy", pc_ready, 1'b0);
      tick();
      drv(0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
      chk("t4_pc_ready", pc_ready, 1'b1);
      chk("t4_no_resp", ins_valid, 1'b0);
      tick();

      // Timeout after TMO wait cycles, response held while ins_ready is low
      drv(0, 1, 64'h8000_0040, 0, 0, 0, 0, 64'h0, 0); tick();
      drv(0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0); tick();
      for (int i = 0; i < TMO; i++) begin
         drv(0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
         chk("t5_wait_quiet", ins_valid, 1'b0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, 64'h0, 0, 0, 1, i[0], {$urandom, $urandom}, 0);
         chk("t5_valid_held", ins_valid, 1'b1);
         chk("t5_ins_stable", ins, 32'h0);
         chk("t5_fault_stable", ins_fault, 1'b1);
         tick();
      end
      drv(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 0); tick();
      idle_cyc();

      if (LB) begin
         // Second half of the same line is served from the line buffer
         drv(0, 0, 64'h0, 0, 1, 0, 0, 64'h0, 0); tick();
         drv(0, 1, 64'h8000_0000, 0, 0, 0, 0, 64'h0, 0); tick();
         drv(0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0); tick();
         drv(0, 0, 64'h0, 0, 0, 0, 1, 64'h1111_1111_2222_2222, 0); tick();
         drv(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 0);
         chk("t6_first", ins, 32'h2222_2222);
         tick();
         drv(0, 1, 64'h8000_0004, 0, 0, 0, 0, 64'h0, 0);
         chk("t6_accept", pc_ready, 1'b1);
         tick();
         drv(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 0);
         chk("t6_hit_valid", ins_valid, 1'b1);
         chk("t6_hit_noreq", mem_req, 1'b0);
         chk("t6_hit_ins", ins, 32'h1111_1111);
         chk("t6_hit_fault", ins_fault, 1'b0);
         tick();
      end

      // Random traffic against the model
      rv_div = 2;
      for (int c = 0; c < 4000; c++) begin
         logic [63:0] p;
         int off;
         if (c % 64 == 0) rv_div = ($urandom_range(0, 2) == 0) ? 20 : 2;
         off = $urandom_range(0, 7);
         p = 64'h8000_0000 + 64'($urandom_range(0, 3)) * 8;
         if ($urandom_range(0, 7) == 0) p = {$urandom, $urandom} & ~64'h7;
         p = p + ((off < 3) ? 64'd0 : (off < 6) ? 64'd4 : (off == 6) ? 64'd2 : 64'd1);
         rd = {$urandom, $urandom};
         drv(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, p,
             $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, rv_div - 1) == 0, rd,
             $urandom_range(0, 7) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the number of WAIT cycles without mem_rvalid before the fetch faults.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pc_valid  input  1  core presents a fetch PC.
REQ-005 SHALL have port pc  input  64  fetch address.
REQ-006 SHALL have port pc_ready  output  1  block accepts pc this cycle.
REQ-007 SHALL have port ins_valid  output  1  instruction response valid.
REQ-008 SHALL have port ins  output  32  fetched instruction.
REQ-009 SHALL have port ins_fault  output  1  response carries a fault (misaligned, memory error, timeout).
REQ-010 SHALL have port ins_ready  input  1  core consumes the response.
REQ-011 SHALL have port flush  input  1  discard the in-flight fetch (redirect).
REQ-012 SHALL have port mem_req  output  1  memory read request.
REQ-013 SHALL have port mem_addr  output  64  8-byte-aligned read address.
REQ-014 SHALL have port mem_gnt  input  1  memory accepts the request.
REQ-015 SHALL have port mem_rvalid  input  1  read data valid.
REQ-016 SHALL have port mem_rdata  input  64  read data.
REQ-017 SHALL have port mem_err  input  1  read error, qualified by mem_rvalid.

Function
REQ-018 SHALL implement the FSM states IDLE, REQ, WAIT, RESP and DRAIN.
REQ-019 SHALL drive pc_ready = (state==IDLE) && !flush; a fetch is accepted when pc_valid && pc_ready, and pc is latched on acceptance.
REQ-020 SHALL, on acceptance with pc[1:0]!=0, go to RESP with ins=0 and ins_fault=1, issuing no memory access.
REQ-021 SHALL, on acceptance of an aligned pc, go to REQ.
REQ-022 SHALL drive mem_req=1 and mem_addr={pc[63:3],3'b000} in REQ, holding both stable until mem_gnt; on mem_gnt it SHALL go to WAIT and clear the timeout counter.
REQ-023 SHALL ignore mem_rvalid outside WAIT and DRAIN; the earliest accepted response is the cycle after gnt.
REQ-024 SHALL, in WAIT on mem_rvalid, register ins = pc[2] ? mem_rdata[63:32] : mem_rdata[31:0] and ins_fault = mem_err, then go to RESP.
REQ-025 SHALL increment the WAIT counter each cycle without rvalid; when the counter reaches MEM_TIMEOUT it SHALL go to RESP with ins=0 and ins_fault=1.
REQ-026 SHALL hold ins_valid=1 in RESP, with ins and ins_fault stable until ins_ready, then go to IDLE; a new pc is accepted no earlier than the cycle after the handshake.
REQ-027 SHALL have a minimum miss latency of 3 cycles from acceptance to ins_valid (gnt in the first REQ cycle, rvalid in the first WAIT cycle).
REQ-028 SHALL handle flush as follows: IDLE→IDLE (pc not accepted); REQ without gnt→IDLE; REQ with gnt in the same cycle→DRAIN; WAIT→DRAIN (or IDLE if rvalid is present in that cycle); RESP→IDLE with the response dropped.
REQ-029 SHALL, in DRAIN, keep ins_valid=0 and go to IDLE on mem_rvalid or on timeout.
REQ-030 SHALL drive ins_valid=0 and mem_req=0 in every state other than RESP and REQ respectively.

Reset
REQ-031 SHALL, while rst=1, set state=IDLE, ins_valid=0, ins=0, ins_fault=0, mem_req=0, mem_addr=0, clear the timeout counter and invalidate the line buffer.
REQ-032 SHALL treat rst asserted mid-fetch (any state) as returning to IDLE next edge; a late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-033 SHALL, with IFU_LINEBUF_EN defined, keep a one-entry line buffer (valid, tag=pc[63:3], 64-bit data), written on every mem_rvalid in WAIT with mem_err=0.
REQ-034 SHALL, with IFU_LINEBUF_EN defined, treat an aligned accepted pc whose tag matches a valid entry as a hit: go directly to RESP with the selected half, giving 1-cycle latency and no mem_req; flush SHALL invalidate the entry.
REQ-035 SHALL, without IFU_LINEBUF_EN, omit all line-buffer logic, so every aligned fetch goes to REQ.

Structure
REQ-036 SHALL place the FSM state enum, the fault-instruction constant (32'h0) and the timeout counter width in shared package ifu_pkg, using the existing CPU_WIDTH define for address and data widths.
REQ-037 SHALL implement the line buffer as sub-module ifu_linebuf, instantiated only under IFU_LINEBUF_EN.

Verification
REQ-038 SHALL cover: pc=0x80000004, gnt at once, rvalid next cycle with rdata=0x00100093_00000513 -> ins=0x00100093, fault=0, ins_valid 3 cycles after accept.
REQ-039 SHALL cover: pc=0x80000002 -> no mem_req, ins_valid next cycle, ins=0, ins_fault=1.
REQ-040 SHALL cover: mem_gnt withheld 4 cycles, then rvalid with mem_err=1 -> mem_addr stable while waiting, ins_fault=1.
REQ-041 SHALL cover: flush in WAIT, rvalid 2 cycles later -> no ins_valid, pc_ready=1 the cycle after rvalid.
REQ-042 SHALL cover: no rvalid with MEM_TIMEOUT=8 -> fault response after 8 WAIT cycles; ins_ready held low 5 cycles -> ins stable.
REQ-043 SHALL cover, with IFU_LINEBUF_EN: fetch 0x80000000 then 0x80000004 -> second fetch has no mem_req and ins_valid 1 cycle after accept.
